// File: rtl/prog_loader.sv
// Boot-time loader: receives a LEN/DATA/CSUM framed byte stream and writes it into memory.
// When the checksum matches it releases core reset and passes the core's write port through.
module prog_loader #(
    parameter int             n         = 8,
    parameter logic [n-1:0]   BASE_ADDR = '0,
    parameter int             TIMEOUT   = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         start,
    input  logic [n-1:0] cpu_wr_data,
    input  logic [n-1:0] cpu_wr_addr,
    input  logic         cpu_wr_en,
    output logic [n-1:0] mem_wr_data,
    output logic [n-1:0] mem_wr_addr,
    output logic         mem_wr_en,
    output logic         core_reset,
    output logic         load_done,
    output logic         load_error
);

    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

    state_t       state;
    logic [n-1:0] cnt;
    logic [n-1:0] addr;
    logic [n-1:0] sum;
    logic [15:0]  idle;
    logic         xfer;
    logic         timeout_hit;

    assign in_ready    = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign xfer        = in_valid && in_ready;
    // One cycle early compare so the move to ERR lands on the edge where idle reaches TIMEOUT.
    assign timeout_hit = (TIMEOUT > 0) && (idle == 16'(TIMEOUT - 1));

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_addr = addr;
        mem_wr_data = in_data;
        case (state)
            S_DATA: mem_wr_en = in_valid;
            S_RUN: begin
                mem_wr_en   = cpu_wr_en;
                mem_wr_addr = cpu_wr_addr;
                mem_wr_data = cpu_wr_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_LEN;
            cnt        <= '0;
            addr       <= BASE_ADDR;
            sum        <= '0;
            idle       <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            case (state)
                S_LEN: begin
                    if (xfer) begin
                        cnt   <= in_data;
                        addr  <= BASE_ADDR;
                        sum   <= '0;
                        idle  <= '0;
                        state <= (in_data == '0) ? S_CSUM : S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        addr <= addr + n'(1);
                        sum  <= sum + in_data;
                        cnt  <= cnt - n'(1);
                        idle <= '0;
                        if (cnt == n'(1))
                            state <= S_CSUM;
                    end else if (timeout_hit) begin
                        state      <= S_ERR;
                        load_error <= 1'b1;
                    end else if (TIMEOUT > 0) begin
                        idle <= idle + 16'd1;
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        idle <= '0;
                        if (in_data == sum) begin
                            state      <= S_RUN;
                            core_reset <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            state      <= S_ERR;
                            load_error <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state      <= S_ERR;
                        load_error <= 1'b1;
                    end else if (TIMEOUT > 0) begin
                        idle <= idle + 16'd1;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        state      <= S_LEN;
                        core_reset <= 1'b1;
                        load_done  <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (start) begin
                        state      <= S_LEN;
                        load_error <= 1'b0;
                    end
                end
                default: state <= S_LEN;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one instance at BASE_ADDR=0/no timeout, one at BASE_ADDR=FE/TIMEOUT=4.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cpu_wr_data = '0;
    logic [7:0] cpu_wr_addr = '0;
    logic       cpu_wr_en = 1'b0;

    logic       in_ready0, mem_wr_en0, core_reset0, load_done0, load_error0;
    logic [7:0] mem_wr_data0, mem_wr_addr0;
    logic       in_ready1, mem_wr_en1, core_reset1, load_done1, load_error1;
    logic [7:0] mem_wr_data1, mem_wr_addr1;

    int total = 0;
    int bad   = 0;

    logic [7:0] wa0[$], wd0[$], wa1[$], wd1[$];

    always #5 clk = ~clk;

    prog_loader #(.n(8), .BASE_ADDR(8'h00), .TIMEOUT(0)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
        .start(start), .cpu_wr_data(cpu_wr_data), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_en(cpu_wr_en),
        .mem_wr_data(mem_wr_data0), .mem_wr_addr(mem_wr_addr0), .mem_wr_en(mem_wr_en0),
        .core_reset(core_reset0), .load_done(load_done0), .load_error(load_error0)
    );

    prog_loader #(.n(8), .BASE_ADDR(8'hFE), .TIMEOUT(4)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .start(start), .cpu_wr_data(cpu_wr_data), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_en(cpu_wr_en),
        .mem_wr_data(mem_wr_data1), .mem_wr_addr(mem_wr_addr1), .mem_wr_en(mem_wr_en1),
        .core_reset(core_reset1), .load_done(load_done1), .load_error(load_error1)
    );

    // Memory-side write logs, sampled exactly when memory would sample.
    always @(posedge clk) begin
        if (mem_wr_en0) begin wa0.push_back(mem_wr_addr0); wd0.push_back(mem_wr_data0); end
        if (mem_wr_en1) begin wa1.push_back(mem_wr_addr1); wd1.push_back(mem_wr_data1); end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] s;

        // Reset state
        tick();
        chk("rst_core_reset", core_reset0, 1);
        chk("rst_load_done", load_done0, 0);
        chk("rst_load_error", load_error0, 0);
        chk("rst_mem_wr_en", mem_wr_en0, 0);
        chk("rst_in_ready", in_ready0, 1);
        do_reset();

        // 1: good frame
        send(8'h03); send(8'hA1); send(8'h02); send(8'h10);
        chk("t1_core_reset_pre", core_reset0, 1);
        send(8'hB3);
        chk("t1_load_done", load_done0, 1);
        chk("t1_core_reset", core_reset0, 0);
        chk("t1_in_ready", in_ready0, 0);
        chk("t1_wcount", wa0.size(), 3);
        if (wa0.size() == 3) begin
            chk("t1_w0", {wa0[0], wd0[0]}, 16'h00A1);
            chk("t1_w1", {wa0[1], wd0[1]}, 16'h0102);
            chk("t1_w2", {wa0[2], wd0[2]}, 16'h0210);
        end

        // 2: bad checksum
        do_reset();
        send(8'h03); send(8'hA1); send(8'h02); send(8'h10); send(8'hB4);
        chk("t2_load_error", load_error0, 1);
        chk("t2_load_done", load_done0, 0);
        chk("t2_core_reset", core_reset0, 1);
        cpu_wr_en = 1'b1;
        #1;
        chk("t2_mem_wr_en_blocked", mem_wr_en0, 0);
        tick();
        chk("t2_core_reset_hold", core_reset0, 1);
        cpu_wr_en = 1'b0;

        // 3: empty frame, then passthrough, then restart
        do_reset();
        send(8'h00);
        chk("t3_not_run_yet", load_done0, 0);
        send(8'h00);
        chk("t3_load_done", load_done0, 1);
        chk("t3_wcount", wa0.size(), 0);
        cpu_wr_data = 8'h7F; cpu_wr_addr = 8'h20; cpu_wr_en = 1'b1;
        #1;
        chk("t3_pass", {mem_wr_en0, mem_wr_addr0, mem_wr_data0}, {1'b1, 8'h20, 8'h7F});
        pulse_start();
        chk("t3_restart_core_reset", core_reset0, 1);
        chk("t3_restart_in_ready", in_ready0, 1);
        chk("t3_restart_no_pass", mem_wr_en0, 0);
        cpu_wr_en = 1'b0;

        // 4: BASE_ADDR=FE with one-cycle gaps between bytes
        do_reset();
        send(8'h03); tick();
        send(8'h11); tick();
        send(8'h22); tick();
        send(8'h33); tick();
        send(8'h66);
        chk("t4_load_done", load_done1, 1);
        chk("t4_wcount", wa1.size(), 3);
        if (wa1.size() == 3) begin
            chk("t4_w0", {wa1[0], wd1[0]}, 16'hFE11);
            chk("t4_w1", {wa1[1], wd1[1]}, 16'hFF22);
            chk("t4_w2", {wa1[2], wd1[2]}, 16'h0033);
        end

        // 5: reset mid-load, then full reload
        do_reset();
        send(8'h03); send(8'hA1); send(8'h02);
        reset = 1'b1;
        #1;
        chk("t5_async_core_reset", core_reset0, 1);
        chk("t5_async_in_ready", in_ready0, 1);
        chk("t5_async_wr_en", mem_wr_en0, 0);
        do_reset();
        send(8'h03); send(8'hA1); send(8'h02); send(8'h10); send(8'hB3);
        chk("t5_reload_done", load_done0, 1);
        chk("t5_reload_core_reset", core_reset0, 0);
        chk("t5_wcount", wa0.size(), 3);

        // 6: stall in DATA with TIMEOUT=4
        do_reset();
        send(8'h03); send(8'h11);
        tick(); tick(); tick();
        chk("t6_no_timeout_yet", load_error1, 0);
        tick();
        chk("t6_timeout_err", load_error1, 1);
        chk("t6_err_in_ready", in_ready1, 0);
        pulse_start();
        chk("t6_start_in_ready", in_ready1, 1);
        chk("t6_start_err_clear", load_error1, 0);
        chk("t6_start_core_reset", core_reset1, 1);

        // LEN=255: last write at base+254
        do_reset();
        send(8'hFF);
        s = 8'h00;
        for (int i = 0; i < 255; i++) begin
            send(8'(i));
            s = s + 8'(i);
        end
        chk("t7_csum_value", s, 8'h81);
        send(s);
        chk("t7_done0", load_done0, 1);
        chk("t7_wcount0", wa0.size(), 255);
        chk("t7_wcount1", wa1.size(), 255);
        if (wa0.size() == 255) chk("t7_last0", {wa0[254], wd0[254]}, 16'hFEFE);
        if (wa1.size() == 255) chk("t7_last1", {wa1[254], wd1[254]}, 16'hFCFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
